// File: rtl/ship_motion_ctrl.sv
// ship_motion_ctrl: per-frame player ship state (position, signed velocity,
// life cycle) plus a combinational pixel test against the beam position.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_ALIVE   | normal flight, controls active, hit starts an explosion
// ST_EXPLODE | ship hidden and frozen, controls and hit ignored
// ST_INVULN  | respawned at centre, controls active, hit ignored, blinks
module ship_motion_ctrl #(
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int WRAP           = 1,
  parameter int MARGIN         = 12,
  parameter int MAX_SPEED      = 4,
  parameter int ACCEL          = 1,
  parameter int FRICTION_DIV   = 8,
  parameter int EXPLODE_FRAMES = 60,
  parameter int INVULN_FRAMES  = 120,
  parameter int HALF_SIZE      = 10
) (
  input  logic       clk_60hz,
  input  logic       reset,
  input  logic       left,
  input  logic       right,
  input  logic       up,
  input  logic       down,
  input  logic       hit,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       pixel,
  output logic [9:0] shipX,
  output logic [9:0] shipY,
  output logic [4:0] velX,
  output logic [4:0] velY,
  output logic       alive,
  output logic       invuln
);

  typedef enum logic [1:0] {ST_ALIVE, ST_EXPLODE, ST_INVULN} state_t;

  // Life counter must hold the longer of the two phases and keep bit 3 for the blink.
  localparam int LIFE_MAX = (EXPLODE_FRAMES > INVULN_FRAMES) ? EXPLODE_FRAMES : INVULN_FRAMES;
  localparam int CNT_W    = (LIFE_MAX > 16) ? $clog2(LIFE_MAX) : 4;
  localparam int FRIC_W   = (FRICTION_DIV > 2) ? $clog2(FRICTION_DIV) : 1;

  localparam logic [CNT_W-1:0]   EXP_LOAD  = CNT_W'(EXPLODE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   INV_LOAD  = CNT_W'(INVULN_FRAMES - 1);
  localparam logic [FRIC_W-1:0]  FRIC_LAST = FRIC_W'(FRICTION_DIV - 1);
  localparam logic signed [6:0]  VMAX      = 7'(MAX_SPEED);
  localparam logic signed [6:0]  VACC      = 7'(ACCEL);
  localparam logic signed [10:0] SW        = 11'(SCREEN_W);
  localparam logic signed [10:0] SH        = 11'(SCREEN_H);
  localparam logic signed [10:0] LO        = 11'(MARGIN);
  localparam logic signed [10:0] XHI       = 11'(SCREEN_W - 1 - MARGIN);
  localparam logic signed [10:0] YHI       = 11'(SCREEN_H - 1 - MARGIN);
  localparam logic signed [10:0] HS        = 11'(HALF_SIZE);
  localparam logic signed [10:0] NS        = 11'(HALF_SIZE + 2);
  localparam logic [9:0]         CX        = 10'(SCREEN_W / 2);
  localparam logic [9:0]         CY        = 10'(SCREEN_H / 2);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRIC_W-1:0]  fric_q, fric_d;
  logic [9:0]         shipx_q, shipx_d, shipy_q, shipy_d;
  logic [4:0]         velx_q, velx_d, vely_q, vely_d;

  logic               fric_tick;
  logic [9:0]         mx, my;
  logic [4:0]         mvx, mvy;

  // One axis of velocity: accelerate with saturation, else friction toward zero.
  function automatic logic [4:0] vel_step(input logic [4:0] v, input logic dec,
                                          input logic inc, input logic fric);
    logic signed [6:0] vs;
    logic signed [6:0] t;
    vs = $signed({{2{v[4]}}, v});
    t  = vs;
    if (inc && !dec) begin
      t = vs + VACC;
      if (t > VMAX) t = VMAX;
    end else if (dec && !inc) begin
      t = vs - VACC;
      if (t < -VMAX) t = -VMAX;
    end else if (fric) begin
      if (vs > 0)      t = vs - 7'sd1;
      else if (vs < 0) t = vs + 7'sd1;
    end
    return t[4:0];
  endfunction

  // One axis of position; returns {clamped, new_pos}. Signed 11-bit sum avoids aliasing.
  function automatic logic [10:0] pos_step(input logic [9:0] p, input logic [4:0] v,
                                           input logic signed [10:0] ext,
                                           input logic signed [10:0] hi);
    logic signed [10:0] s;
    logic [9:0]         r;
    logic               c;
    s = $signed({1'b0, p}) + $signed({{6{v[4]}}, v});
    c = 1'b0;
    if (WRAP != 0) begin
      if (s < 0)         s = s + ext;
      else if (s >= ext) s = s - ext;
      r = s[9:0];
    end else begin
      r = s[9:0];
      if (s < LO) begin
        r = LO[9:0];
        c = 1'b1;
      end else if (s > hi) begin
        r = hi[9:0];
        c = 1'b1;
      end
    end
    return {c, r};
  endfunction

  // Free-running motion result for this frame; the FSM decides whether it is used.
  always_comb begin
    logic [10:0] px;
    logic [10:0] py;
    fric_tick = (fric_q == FRIC_LAST);
    fric_d    = fric_tick ? '0 : fric_q + 1'b1;
    px        = pos_step(shipx_q, velx_q, SW, XHI);
    py        = pos_step(shipy_q, vely_q, SH, YHI);
    mx        = px[9:0];
    my        = py[9:0];
    mvx       = px[10] ? 5'd0 : vel_step(velx_q, left, right, fric_tick);
    mvy       = py[10] ? 5'd0 : vel_step(vely_q, up, down, fric_tick);
  end

  // Life-cycle next state together with the registered game state it controls.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shipx_d = shipx_q;
    shipy_d = shipy_q;
    velx_d  = velx_q;
    vely_d  = vely_q;
    case (state_q)
      ST_ALIVE: begin
        if (hit) begin
          state_d = ST_EXPLODE;
          cnt_d   = EXP_LOAD;
          velx_d  = '0;
          vely_d  = '0;
        end else begin
          shipx_d = mx;
          shipy_d = my;
          velx_d  = mvx;
          vely_d  = mvy;
        end
      end
      ST_EXPLODE: begin
        if (cnt_q == '0) begin
          state_d = ST_INVULN;
          cnt_d   = INV_LOAD;
          shipx_d = CX;
          shipy_d = CY;
          velx_d  = '0;
          vely_d  = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_INVULN: begin
        shipx_d = mx;
        shipy_d = my;
        velx_d  = mvx;
        vely_d  = mvy;
        if (cnt_q == '0) state_d = ST_ALIVE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_ALIVE;
    endcase
  end

  // Frame-rate state register with synchronous reset to the centred, stationary ship.
  always_ff @(posedge clk_60hz) begin
    if (reset) begin
      state_q <= ST_ALIVE;
      cnt_q   <= '0;
      fric_q  <= '0;
      shipx_q <= CX;
      shipy_q <= CY;
      velx_q  <= '0;
      vely_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fric_q  <= fric_d;
      shipx_q <= shipx_d;
      shipy_q <= shipy_d;
      velx_q  <= velx_d;
      vely_q  <= vely_d;
    end
  end

  // Ship shape test against the beam; signed differences keep edges near 0 correct.
  always_comb begin
    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic signed [10:0] adx;
    logic signed [10:0] ady;
    logic               shape;
    logic               show;
    dx    = $signed({1'b0, x}) - $signed({1'b0, shipx_q});
    dy    = $signed({1'b0, y}) - $signed({1'b0, shipy_q});
    adx   = (dx < 0) ? -dx : dx;
    ady   = (dy < 0) ? -dy : dy;
    shape = ((adx < HS) && (ady < HS)) || ((adx < 11'sd1) && (ady < NS));
    show  = (state_q == ST_ALIVE) || ((state_q == ST_INVULN) && cnt_q[3]);
    pixel = shape && show;
  end

  assign shipX  = shipx_q;
  assign shipY  = shipy_q;
  assign velX   = velx_q;
  assign velY   = vely_q;
  assign alive  = (state_q != ST_EXPLODE);
  assign invuln = (state_q == ST_INVULN);

endmodule

// File: tb/tb_ship_motion_ctrl.sv
// Directed bench for ship_motion_ctrl: a wrapping instance and a clamping
// instance share the stimulus; expectations are hand-computed per frame.
module tb_ship_motion_ctrl;

  logic       clk;
  logic       reset, left, right, up, down, hit;
  logic [9:0] bx, by;

  logic       w_pixel, w_alive, w_invuln;
  logic [9:0] w_shipx, w_shipy;
  logic [4:0] w_velx, w_vely;

  logic       c_pixel, c_alive, c_invuln;
  logic [9:0] c_shipx, c_shipy;
  logic [4:0] c_velx, c_vely;

  int n_cmp = 0;
  int n_bad = 0;

  ship_motion_ctrl #(.WRAP(1)) u_wrap (
    .clk_60hz(clk), .reset(reset), .left(left), .right(right), .up(up), .down(down),
    .hit(hit), .x(bx), .y(by), .pixel(w_pixel), .shipX(w_shipx), .shipY(w_shipy),
    .velX(w_velx), .velY(w_vely), .alive(w_alive), .invuln(w_invuln)
  );

  ship_motion_ctrl #(.WRAP(0)) u_clamp (
    .clk_60hz(clk), .reset(reset), .left(left), .right(right), .up(up), .down(down),
    .hit(hit), .x(bx), .y(by), .pixel(c_pixel), .shipX(c_shipx), .shipY(c_shipy),
    .velX(c_velx), .velY(c_vely), .alive(c_alive), .invuln(c_invuln)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_beam(input int px, input int py);
    bx = 10'(px);
    by = 10'(py);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    left = 1'b0; right = 1'b0; up = 1'b0; down = 1'b0; hit = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    int exp_v[6];
    exp_v = '{1, 2, 3, 4, 4, 4};
    bx = 10'd0; by = 10'd0;

    // Reset state
    do_reset();
    chk("rst_shipx", w_shipx, 320);
    chk("rst_shipy", w_shipy, 240);
    chk("rst_velx", $signed(w_velx), 0);
    chk("rst_vely", $signed(w_vely), 0);
    chk("rst_alive", w_alive, 1);
    chk("rst_invuln", w_invuln, 0);

    // Acceleration and saturation
    right = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk($sformatf("acc_velx_%0d", i), $signed(w_velx), exp_v[i]);
    end
    chk("acc_shipx", w_shipx, 334);
    chk("acc_shipy", w_shipy, 240);

    // Friction decay: one unit every 8th frame from reset (edges 8,16,24,32)
    right = 1'b0;
    step(2);
    chk("fr_velx_8", $signed(w_velx), 3);
    chk("fr_shipx_8", w_shipx, 342);
    step(8);
    chk("fr_velx_16", $signed(w_velx), 2);
    chk("fr_shipx_16", w_shipx, 366);
    step(8);
    chk("fr_velx_24", $signed(w_velx), 1);
    chk("fr_shipx_24", w_shipx, 382);
    step(8);
    chk("fr_velx_32", $signed(w_velx), 0);
    chk("fr_shipx_32", w_shipx, 390);
    step(4);
    chk("fr_velx_hold", $signed(w_velx), 0);
    chk("fr_shipx_hold", w_shipx, 390);

    // Wrap at right edge then at left edge
    do_reset();
    right = 1'b1;
    step(82);
    chk("wr_shipx_638", w_shipx, 638);
    chk("wr_velx_4", $signed(w_velx), 4);
    step(1);
    chk("wr_shipx_2", w_shipx, 2);
    right = 1'b0;
    left  = 1'b1;
    step(9);
    chk("wl_shipx_2", w_shipx, 2);
    chk("wl_velx_m4", $signed(w_velx), -4);
    step(1);
    chk("wl_shipx_638", w_shipx, 638);
    chk("wl_velx_m4b", $signed(w_velx), -4);
    chk("wl_shipy", w_shipy, 240);

    // Clamp instance: stop at SCREEN_W-1-MARGIN, velocity zeroed on that edge
    do_reset();
    right = 1'b1;
    step(79);
    chk("cl_shipx_626", c_shipx, 626);
    chk("cl_velx_4", $signed(c_velx), 4);
    step(1);
    chk("cl_shipx_627", c_shipx, 627);
    chk("cl_velx_0", $signed(c_velx), 0);
    right = 1'b0;
    left  = 1'b1;
    step(2);
    chk("cl_left_shipx", c_shipx, 626);
    chk("cl_left_velx", $signed(c_velx), -2);
    right = 1'b1;
    step(3);
    chk("cl_both_velx", $signed(c_velx), -2);
    chk("cl_both_shipx", c_shipx, 620);

    // Hit, explosion, respawn, invulnerability
    do_reset();
    left = 1'b1;
    step(6);
    chk("hit_pre_shipx", w_shipx, 306);
    chk("hit_pre_velx", $signed(w_velx), -4);
    hit = 1'b1;
    step(1);
    chk("ex_shipx_frozen", w_shipx, 306);
    chk("ex_velx_0", $signed(w_velx), 0);
    chk("ex_alive", w_alive, 0);
    set_beam(306, 240);
    chk("ex_pixel", w_pixel, 0);
    step(59);
    chk("ex_alive_end", w_alive, 0);
    chk("ex_shipx_end", w_shipx, 306);
    step(1);
    chk("inv_entry", w_invuln, 1);
    chk("inv_alive", w_alive, 1);
    chk("inv_shipx", w_shipx, 320);
    chk("inv_shipy", w_shipy, 240);
    chk("inv_velx", $signed(w_velx), 0);
    left = 1'b0;
    set_beam(320, 240);
    chk("inv_blink_off", w_pixel, 0);
    step(8);
    chk("inv_blink_on", w_pixel, 1);
    chk("inv_hit_ignored", w_invuln, 1);
    hit = 1'b0;
    step(111);
    chk("inv_last", w_invuln, 1);
    step(1);
    chk("inv_done", w_invuln, 0);
    chk("inv_done_alive", w_alive, 1);
    chk("inv_done_shipx", w_shipx, 320);

    // Reset during EXPLODE, simultaneous with hit
    hit = 1'b1;
    step(1);
    hit = 1'b0;
    step(5);
    chk("rx_exploding", w_alive, 0);
    reset = 1'b1;
    hit   = 1'b1;
    step(1);
    reset = 1'b0;
    hit   = 1'b0;
    chk("rx_alive", w_alive, 1);
    chk("rx_invuln", w_invuln, 0);
    chk("rx_shipx", w_shipx, 320);
    chk("rx_shipy", w_shipy, 240);
    chk("rx_velx", $signed(w_velx), 0);

    // Pixel shape around the centred ship
    set_beam(320, 240);
    chk("px_centre", w_pixel, 1);
    set_beam(320, 251);
    chk("px_nose", w_pixel, 1);
    set_beam(320, 252);
    chk("px_nose_end", w_pixel, 0);
    set_beam(331, 240);
    chk("px_right_out", w_pixel, 0);
    set_beam(329, 240);
    chk("px_right_in", w_pixel, 1);
    set_beam(310, 240);
    chk("px_left_out", w_pixel, 0);
    set_beam(311, 249);
    chk("px_corner_in", w_pixel, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ship_motion_ctrl.md
Name: ship_motion_ctrl

Overview:
Parametrised successor to the player ship block. It adds signed velocity with acceleration, saturation and friction. Screen edges either wrap or clamp, selected by parameter. A life-cycle FSM covers ALIVE, EXPLODE and INVULN (respawn blink). Game state updates once per frame on clk_60hz. The pixel output is a combinational function of the registered state and the beam coordinates, and feeds the VGA colour mux.

Parameters:
SCREEN_W, 640, horizontal extent in pixels (positions 0..SCREEN_W-1)
SCREEN_H, 480, vertical extent in pixels
WRAP, 1, 1 = toroidal wrap at edges; 0 = clamp to margin and zero that axis velocity
MARGIN, 12, clamp margin in pixels (used when WRAP=0)
MAX_SPEED, 4, velocity saturation magnitude, pixels/frame
ACCEL, 1, velocity change per frame while a direction is held
FRICTION_DIV, 8, frames between one-unit friction decay steps
EXPLODE_FRAMES, 60, frames spent in EXPLODE
INVULN_FRAMES, 120, frames spent in INVULN
HALF_SIZE, 10, half-width of the ship body square

Ports:
clk_60hz  input  1  frame-rate clock; the only clock
reset  input  1  synchronous, active-high reset
left  input  1  accelerate -X
right  input  1  accelerate +X
up  input  1  accelerate -Y
down  input  1  accelerate +Y
hit  input  1  collision pulse from the asteroid/collision logic
x  input  10  current beam X
y  input  10  current beam Y
pixel  output  1  ship pixel at (x,y), combinational
shipX  output  10  registered ship X
shipY  output  10  registered ship Y
velX  output  5  signed X velocity, two's complement
velY  output  5  signed Y velocity, two's complement
alive  output  1  1 in ALIVE or INVULN
invuln  output  1  1 in INVULN

Behaviour:
- Clock and reset: one clock, clk_60hz. reset is synchronous and active-high and has priority over everything.
- Reset values: shipX=SCREEN_W/2 (320), shipY=SCREEN_H/2 (240), velX=velY=0, state=ALIVE, life counter=0, friction counter=0. Hence alive=1, invuln=0.
- Per-frame order in ALIVE or INVULN:
  - pos_next = pos + vel, using the velocity registered before this edge.
  - Velocity update is computed in parallel and lands on the same edge.
  - A position change is visible one frame after a velocity change.
- Velocity, per axis:
  - Exactly one of the pair held (e.g. left without right): vel moves by ACCEL in that direction.
  - Saturate at ±MAX_SPEED; never wrap.
  - Both held or neither held: no acceleration. If the friction counter equals FRICTION_DIV-1 on this frame, vel moves 1 toward 0; vel=0 stays 0.
- Friction counter: free-running 0..FRICTION_DIV-1, wraps to 0. It runs in every state.
- Position, WRAP=1:
  - Sum below 0: add SCREEN_W (resp. SCREEN_H).
  - Sum ≥ SCREEN_W: subtract SCREEN_W.
  - Compute in 11-bit signed arithmetic so no intermediate aliasing.
- Position, WRAP=0:
  - Clamp to [MARGIN, SCREEN_W-1-MARGIN] (resp. SCREEN_H).
  - On clamp, zero that axis velocity on the same edge.
- FSM:
  - ALIVE: hit=1 → EXPLODE. On that edge: counter=EXPLODE_FRAMES-1, velX=velY=0, position frozen.
  - EXPLODE: controls and hit ignored; counter decrements each frame. At counter=0 → INVULN, position reset to centre, velocity 0, counter=INVULN_FRAMES-1.
  - INVULN: controls active, hit ignored, counter decrements. At counter=0 → ALIVE.
- Pixel:
  - Body: |x-shipX|<HALF_SIZE and |y-shipY|<HALF_SIZE.
  - Nose: |x-shipX|<1 and |y-shipY|<HALF_SIZE+2.
  - Compute the differences signed, so the test does not underflow near 0.
  - pixel=0 in EXPLODE.
  - In INVULN, pixel is gated by counter bit 3 (blink period 16 frames).
  - No wrap-aware drawing: the ship is clipped at screen edges.
- Simultaneous hit and reset: reset wins.
- Hit on the ALIVE-exit edge while inputs are held: the transition to EXPLODE wins and the velocity update is discarded.

Test Plan:
1. Reset, hold right 6 frames → velX: 1,2,3,4,4,4 (saturated); shipX after 6 edges = 320+0+1+2+3+4+4 = 334.
2. velX=4, release all inputs → velX decrements by 1 every 8 frames, reaching 0 after 32 frames; shipX monotonically nondecreasing, then constant.
3. WRAP=1, shipX=638, velX=+4 → next shipX=2; shipX=1, velX=-3 → 638.
4. WRAP=0, shipX=626, velX=+4 → shipX=627, velX=0 on the same edge; left and right held together → no acceleration.
5. Hit in ALIVE at shipX=100 → alive=0, pixel=0, position frozen for 60 frames; then shipX=320, shipY=240, invuln=1; a hit during INVULN is ignored; after 120 frames invuln=0, alive=1.
6. Assert reset mid-EXPLODE → next edge: state ALIVE, centre position, velocity 0; pixel=1 at (320,240) and at (320,251); pixel=0 at (331,240).
